// File: rtl/edge_det_pkg.sv
// Shared mode encodings and sizing helper for the edge event detector.
package edge_det_pkg;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   // Filter counter only has to hold 0..FILT_CNT-1; never narrower than one bit.
   function automatic int unsigned filt_cnt_width(input int unsigned filt_cnt);
      int unsigned w;
      w = (filt_cnt > 1) ? int'($clog2(filt_cnt)) : 1;
      return w;
   endfunction

endpackage

// File: rtl/edge_event_detector_if.sv
// Channel bundle between raw lines / control logic and the edge event detector.
interface edge_event_detector_if #(
   parameter int unsigned CH    = 4,
   parameter int unsigned CNT_W = 8
);

   logic [CH-1:0]       Din;
   logic [2*CH-1:0]     Mode;
   logic [CH-1:0]       Clr;
   logic [CH-1:0]       P;
   logic [CH-1:0]       N;
   logic [CH-1:0]       Flag;
   logic [CH*CNT_W-1:0] Evt_cnt;
   logic                Irq;

   modport master (
      output Din, Mode, Clr,
      input  P, N, Flag, Evt_cnt, Irq
   );

   modport slave (
      input  Din, Mode, Clr,
      output P, N, Flag, Evt_cnt, Irq
   );

endinterface

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, glitch filter, mode-gated edge pulses, sticky flag and
// saturating event counter.
module edge_det_channel
   import edge_det_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CNT    = 3,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Din,
   input  logic [1:0]       Mode,
   input  logic             Clr,
   output logic             P,
   output logic             N,
   output logic             Flag,
   output logic [CNT_W-1:0] Evt_cnt
);

   localparam int unsigned FW = filt_cnt_width(FILT_CNT);
   localparam logic [FW-1:0] FiltLast = FW'(FILT_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   filt_q, filt_d;
   logic [FW-1:0]          fcnt_q, fcnt_d;
   logic                   accept;
   logic                   p_d, n_d;
   logic                   flag_q, flag_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain for the asynchronous input.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], Din};
      end
   end

   // Filter: a new level is accepted only after FILT_CNT consecutive samples.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      accept = 1'b0;
      if (s != filt_q) begin
         if (fcnt_q == FiltLast) begin
            filt_d = s;
            accept = 1'b1;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   // Mode-gated edges drive the flag and counter; an event beats a same-cycle clear.
   always_comb begin
      p_d    = accept & s & ((Mode == MODE_RISE) | (Mode == MODE_BOTH));
      n_d    = accept & ~s & ((Mode == MODE_FALL) | (Mode == MODE_BOTH));
      flag_d = flag_q;
      cnt_d  = cnt_q;
      if (p_d | n_d) begin
         flag_d = 1'b1;
         if (Clr) begin
            cnt_d = CNT_W'(1);
         end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (Clr) begin
         flag_d = 1'b0;
         cnt_d  = '0;
      end
   end

   // Filter, pulse, flag and counter state.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
         P      <= 1'b0;
         N      <= 1'b0;
         flag_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         filt_q <= filt_d;
         fcnt_q <= fcnt_d;
         P      <= p_d;
         N      <= n_d;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
      end
   end

   assign Flag    = flag_q;
   assign Evt_cnt = cnt_q;

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel edge event detector: CH independent channels plus a combined interrupt.
module edge_event_detector
   import edge_det_pkg::*;
#(
   parameter int unsigned CH          = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CNT    = 3,
   parameter int unsigned CNT_W       = 8
) (
   input logic                 Clk,
   input logic                 Rst,
   edge_event_detector_if.slave bus
);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      edge_det_channel #(
         .SYNC_STAGES(SYNC_STAGES),
         .FILT_CNT   (FILT_CNT),
         .CNT_W      (CNT_W)
      ) u_ch (
         .Clk    (Clk),
         .Rst    (Rst),
         .Din    (bus.Din[i]),
         .Mode   (bus.Mode[2*i +: 2]),
         .Clr    (bus.Clr[i]),
         .P      (bus.P[i]),
         .N      (bus.N[i]),
         .Flag   (bus.Flag[i]),
         .Evt_cnt(bus.Evt_cnt[i*CNT_W +: CNT_W])
      );
   end

   // Flags are registered, so their OR changes on the same edge as the flags.
   assign bus.Irq = |bus.Flag;

endmodule

// File: tb/tb_edge_event_detector.sv
// Scoreboard bench: a default 4-channel instance plus a 1-channel CNT_W=2 instance that
// mirrors channel 0 to exercise counter saturation.
module tb_edge_event_detector;

   localparam int SYNC = 2;
   localparam int FILT = 3;
   localparam int NM   = 5;  // model channels 0..3 main, 4 = saturating copy of ch0

   typedef struct {
      logic [3:0]  p, n, flag;
      logic [31:0] cnt;
      logic        irq;
      logic        sp, sn, sflag;
      logic [1:0]  scnt;
      logic        sirq;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst;
   logic [3:0] din;
   logic [7:0] mode;
   logic [3:0] clr;

   int nvec = 0;
   int nerr = 0;

   exp_t sb[$];
   int f_m[NM], flag_m[NM], cnt_m[NM];
   int dq[NM][$];
   int wq[NM][$];

   edge_event_detector_if #(.CH(4), .CNT_W(8)) bus ();
   edge_event_detector_if #(.CH(1), .CNT_W(2)) bus_s ();

   edge_event_detector #(.CH(4), .SYNC_STAGES(SYNC), .FILT_CNT(FILT), .CNT_W(8)) dut (
      .Clk(Clk), .Rst(Rst), .bus(bus)
   );
   edge_event_detector #(.CH(1), .SYNC_STAGES(SYNC), .FILT_CNT(FILT), .CNT_W(2)) dut_s (
      .Clk(Clk), .Rst(Rst), .bus(bus_s)
   );

   always #5 Clk = ~Clk;

   initial begin
      #500us;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
      end
   endtask

   function automatic int maxc(input int c);
      return (c == 4) ? 3 : 255;
   endfunction

   // Reference state after reset: sync delay line and filter window full of zeros.
   task automatic model_reset();
      for (int c = 0; c < NM; c++) begin
         f_m[c] = 0; flag_m[c] = 0; cnt_m[c] = 0;
         dq[c].delete(); wq[c].delete();
         for (int k = 0; k < SYNC; k++) dq[c].push_back(0);
         for (int k = 0; k < FILT; k++) wq[c].push_back(0);
      end
   endtask

   // Drive inputs for the coming edge and push the outputs expected after it.
   task automatic apply();
      exp_t e;
      int ch, m, s, cl;
      bit acc, pe, ne;
      bus.Din = din; bus.Mode = mode; bus.Clr = clr;
      bus_s.Din = din[0]; bus_s.Mode = mode[1:0]; bus_s.Clr = clr[0];
      e.p = '0; e.n = '0; e.flag = '0; e.cnt = '0; e.irq = 1'b0;
      e.sp = 1'b0; e.sn = 1'b0; e.sflag = 1'b0; e.scnt = '0; e.sirq = 1'b0;
      for (int c = 0; c < NM; c++) begin
         ch = (c < 4) ? c : 0;
         m  = int'(mode[2*ch +: 2]);
         cl = int'(clr[ch]);
         dq[c].push_back(int'(din[ch]));
         s = dq[c].pop_front();
         wq[c].push_back(s);
         if (wq[c].size() > FILT) void'(wq[c].pop_front());
         // A level is accepted once the last FILT synced samples all differ from it.
         acc = 1'b1;
         for (int k = 0; k < wq[c].size(); k++) if (wq[c][k] == f_m[c]) acc = 1'b0;
         pe = 1'b0; ne = 1'b0;
         if (acc) begin
            f_m[c] = 1 - f_m[c];
            pe = (f_m[c] == 1) && (m == 1 || m == 3);
            ne = (f_m[c] == 0) && (m == 2 || m == 3);
         end
         if (pe || ne) begin
            flag_m[c] = 1;
            if (cl != 0) cnt_m[c] = 1;
            else if (cnt_m[c] < maxc(c)) cnt_m[c] = cnt_m[c] + 1;
         end else if (cl != 0) begin
            flag_m[c] = 0;
            cnt_m[c] = 0;
         end
         if (c < 4) begin
            e.p[c] = pe; e.n[c] = ne; e.flag[c] = (flag_m[c] != 0);
            e.cnt[c*8 +: 8] = 8'(cnt_m[c]);
         end else begin
            e.sp = pe; e.sn = ne; e.sflag = (flag_m[c] != 0); e.scnt = 2'(cnt_m[c]);
         end
      end
      e.irq = |e.flag;
      e.sirq = e.sflag;
      sb.push_back(e);
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge Clk);
         apply();
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".P"}, 32'(bus.P), 32'd0);
      check({tag, ".N"}, 32'(bus.N), 32'd0);
      check({tag, ".Flag"}, 32'(bus.Flag), 32'd0);
      check({tag, ".Evt_cnt"}, bus.Evt_cnt, 32'd0);
      check({tag, ".Irq"}, 32'(bus.Irq), 32'd0);
      check({tag, ".sat_Flag"}, 32'(bus_s.Flag), 32'd0);
      check({tag, ".sat_Evt_cnt"}, 32'(bus_s.Evt_cnt), 32'd0);
   endtask

   // Monitor: compare every DUT output against the queued expectation after each edge.
   always @(posedge Clk) begin
      exp_t g;
      #1;
      if (sb.size() > 0) begin
         g = sb.pop_front();
         check("P", 32'(bus.P), 32'(g.p));
         check("N", 32'(bus.N), 32'(g.n));
         check("Flag", 32'(bus.Flag), 32'(g.flag));
         check("Evt_cnt", bus.Evt_cnt, g.cnt);
         check("Irq", 32'(bus.Irq), 32'(g.irq));
         check("sat_P", 32'(bus_s.P), 32'(g.sp));
         check("sat_N", 32'(bus_s.N), 32'(g.sn));
         check("sat_Flag", 32'(bus_s.Flag), 32'(g.sflag));
         check("sat_Evt_cnt", 32'(bus_s.Evt_cnt), 32'(g.scnt));
         check("sat_Irq", 32'(bus_s.Irq), 32'(g.sirq));
      end
   end

   initial begin
      Rst = 1'b1; din = '0; mode = '0; clr = '0;
      bus.Din = '0; bus.Mode = '0; bus.Clr = '0;
      bus_s.Din = '0; bus_s.Mode = '0; bus_s.Clr = '0;
      #2;
      check_zero("reset_noclk");
      @(negedge Clk);
      Rst = 1'b0;
      model_reset();
      apply();

      // Single rising edge on channel 0.
      mode = 8'b0000_0001;
      run(3);
      din[0] = 1'b1;
      run(10);

      // Both edges: 2-cycle glitch rejected, 3-cycle pulse accepted.
      din[0] = 1'b0; mode[1:0] = 2'b11;
      run(8);
      din[0] = 1'b1; run(2);
      din[0] = 1'b0; run(8);
      din[0] = 1'b1; run(3);
      din[0] = 1'b0; run(10);

      // Channel 1 falling only, channel 2 off.
      mode = {2'b00, 2'b00, 2'b10, 2'b11};
      repeat (4) begin
         din[1] = ~din[1]; din[2] = ~din[2];
         run(10);
      end

      // Five accepted rises: saturating copy stops at 3.
      mode = 8'b0000_0001;
      clr = 4'b1110; run(1); clr = '0;
      repeat (5) begin
         din[0] = 1'b1; run(5);
         din[0] = 1'b0; run(5);
      end

      // Clear coinciding with an accepted rise, then clear alone.
      run(5);
      din[0] = 1'b1;
      run(4);
      clr = 4'b0001; run(1);
      clr = 4'b1111; run(1);
      clr = '0; run(3);

      // Asynchronous reset mid-filter with input held high.
      din[0] = 1'b0; run(8);
      din[0] = 1'b1; run(3);
      @(posedge Clk);
      #3;
      Rst = 1'b1;
      #1;
      check_zero("reset_async");
      @(negedge Clk);
      Rst = 1'b0;
      model_reset();
      apply();
      run(10);

      // Randomised traffic with occasional mode changes and clears.
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (cyc % 50 == 0) mode = 8'($urandom);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(3) == 0) din[i] = ~din[i];
            clr[i] = ($urandom_range(15) == 0);
         end
         run(1);
      end
      clr = '0;
      run(2);
      @(negedge Clk);
      @(negedge Clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
